decode_stage: RTL and testbench
===============================

# decode_stage

Registered RV32I/RV64I instruction-decode pipeline stage with a valid/ready handshake and a two-entry skid buffer. Sits between fetch and register-read/execute. Extracts fields and the XLEN-wide sign-extended immediate, classifies the instruction format, and flags illegal encodings. Supports optional M-extension and RV64 opcodes. Sustains one instruction per cycle under back-pressure without a combinational ready path.

## Interface

Parameters:
- XLEN, 32: datapath width, 32 or 64; sets `imm_o`/`pc_o` width and enables OP-IMM-32/OP-32 opcodes at 64.
- EN_M, 0: 1 makes funct7=0000001 on OP (and OP-32 when XLEN=64) legal.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all held instructions.
- in_valid_i  in  1  upstream instruction valid.
- in_ready_o  out  1  stage can accept; registered.
- instr_i  in  32  raw instruction.
- pc_i  in  XLEN  instruction address.
- out_valid_o  out  1  decoded instruction valid.
- out_ready_i  in  1  downstream accepts.
- opcode_o, funct3_o, funct7_o  out  7/3/7  instruction fields.
- rd_addr_o, rs1_addr_o, rs2_addr_o  out  5 each  register addresses.
- imm_o  out  XLEN  sign-extended immediate; 0 for R-type and illegal.
- pc_o  out  XLEN  PC of the presented instruction.
- fmt_o  out  3  format: R, I, S, B, U, J, X (illegal).
- illegal_o  out  1  illegal encoding.

## Operation

- Decode is combinational on `instr_i`. The decoded payload is written to the output register (OUT), or to the skid register (SKID) when OUT is stalled.
- Input transfer occurs when `in_valid_i & in_ready_o`. Output transfer occurs when `out_valid_o & out_ready_i`.
- State machine:
  - EMPTY: accept leads to ONE.
  - ONE: output transfer without accept leads to EMPTY. Accept with output transfer stays in ONE, and OUT loads the new instruction. Accept without output transfer leads to TWO, and the instruction goes to SKID.
  - TWO: output transfer leads to ONE, and SKID moves to OUT.
- `in_ready_o` = 1 in EMPTY and ONE, 0 in TWO.
- `out_valid_o` = 1 in ONE and TWO. Order is strictly preserved.
- flush_i:
  - Next state is EMPTY.
  - A same-cycle input transfer is dropped.
  - A same-cycle output transfer still counts as completed downstream.
  - Priority: rst_i, then flush_i, then handshakes.
- Immediate rules:
  - I (OP-IMM, LOAD, JALR, OP-IMM-32) = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U = sext({instr[31:12], 12'b0}); at XLEN=64, bit 31 is extended.
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- An instruction is illegal when any of these holds:
  - instr[1:0] != 11.
  - Unknown opcode.
  - BRANCH funct3 is 010 or 011.
  - LOAD funct3 is 011 (at 32), 110 (at 32), or 111.
  - STORE funct3 is above 010 (at 32) or above 011 (at 64).
  - JALR funct3 != 0.
  - OP funct7 is not 0000000, not 0100000 (only valid with funct3 000 or 101), and not 0000001 (only valid with EN_M).
  - SLLI/SRLI/SRAI upper bits are non-zero: instr[31:25] at 32, instr[31:26] at 64, with bit 30 allowed for SRAI.
  - OP-IMM-32/OP-32 is used when XLEN=32.
- Illegal instructions still flow through the stage, with `illegal_o`=1, `fmt_o`=X, and `imm_o`=0. Raw fields are passed unchanged.

## Timing

- Reset: after the first clock edge with `rst_i`=1, the state is EMPTY, `out_valid_o`=0, `in_ready_o`=1, and all payload outputs are 0.
- Latency is one cycle: an instruction accepted at edge N is presented after edge N.
- Throughput is one instruction per cycle with `out_ready_i` held high.
- `in_ready_o` depends only on state; there is no combinational in-to-out ready path.
- Outputs stay stable while `out_valid_o & !out_ready_i`.
- Reset asserted in TWO drops both entries.

## Structure

- `decode_pkg` holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP_32, OP_IMM_32);
  - funct7 constants;
  - `fmt_e` enum;
  - packed `dec_payload_t` struct, parametrised via XLEN-width fields in the module.
- One sub-module, `instr_field_dec`: combinational field extraction, immediate generation and legality check, parametrised by XLEN and EN_M. It is instantiated once on the input side. SKID stores the decoded payload.

## Test plan

- **ADDI:** `addi x1,x0,-1` (0xFFF00093) with pc 0x100, out_ready=1. Required: after one cycle, opcode 0010011, rd 1, rs1 0, imm 0xFFFFFFFF, fmt I, illegal 0, pc_o 0x100.
- **Back-pressure:** out_ready=0, send A, B, C back-to-back. Required: `in_ready_o` falls after B and C is held upstream. Release out_ready: A, B, C emerge on consecutive cycles with no loss or duplication.
- **Flush:** assert flush_i in TWO together with a new input. Required: next cycle `out_valid_o`=0 and `in_ready_o`=1; the new input never appears.
- **M extension:** `mul x3,x1,x2` (0x022081B3). Required: illegal 1 and fmt X with EN_M=0; illegal 0 and fmt R with EN_M=1.
- **XLEN=64:** `jal x0,-4` (0xFFDFF06F) requires imm 0xFFFFFFFFFFFFFFFC. `addiw x1,x0,1` (0x0010009B) is legal with imm 1; the same word at XLEN=32 gives illegal 1.
- **Reset in TWO:** pulse rst_i one cycle while in TWO. Required: `out_valid_o`=0, `in_ready_o`=1, payload 0; the first post-reset instruction appears after one cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode/funct7 constants, instruction format enum and decoded payload
// layout for the RV32I/RV64I decode stage.
package decode_pkg;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // XLEN-independent part of a decoded instruction; imm and pc are added by
  // the stage, which knows XLEN.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    fmt_e       fmt;
    logic       illegal;
  } dec_payload_t;

endpackage

// File: rtl/instr_field_dec.sv
// Combinational RV32I/RV64I field extraction, immediate generation and
// legality check.
module instr_field_dec
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0]     instr,
  output dec_payload_t    fields,
  output logic [XLEN-1:0] imm
);

  localparam bit RV64 = (XLEN == 64);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = (i < 32) ? v[i[4:0]] : v[31];
    return r;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        shift_upper_zero, srai_upper_ok, op_funct7_ok, legal;
  fmt_e        fmt;

  always_comb begin
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];

    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'b0};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // RV64 shift amounts are 6 bits wide, so instr[25] belongs to shamt there
    shift_upper_zero = RV64 ? (instr[31:26] == 6'b000000) : (instr[31:25] == F7_BASE);
    srai_upper_ok    = RV64 ? (instr[31:26] == 6'b010000) : (instr[31:25] == F7_ALT);
    op_funct7_ok     = (funct7 == F7_BASE)
                    || ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
                    || ((funct7 == F7_MULDIV) && EN_M);

    legal = 1'b1;
    fmt   = FMT_X;
    imm   = '0;
    case (opcode)
      LUI, AUIPC: begin
        fmt = FMT_U;
        imm = sext32(imm_u);
      end
      JAL: begin
        fmt = FMT_J;
        imm = sext32(imm_j);
      end
      JALR: begin
        fmt   = FMT_I;
        imm   = sext32(imm_i);
        legal = (funct3 == 3'b000);
      end
      BRANCH: begin
        fmt   = FMT_B;
        imm   = sext32(imm_b);
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      LOAD: begin
        fmt   = FMT_I;
        imm   = sext32(imm_i);
        legal = (funct3 != 3'b111) && (RV64 || ((funct3 != 3'b011) && (funct3 != 3'b110)));
      end
      STORE: begin
        fmt   = FMT_S;
        imm   = sext32(imm_s);
        legal = RV64 ? (funct3 <= 3'b011) : (funct3 <= 3'b010);
      end
      OP_IMM: begin
        fmt = FMT_I;
        imm = sext32(imm_i);
        if (funct3 == 3'b001) legal = shift_upper_zero;
        else if (funct3 == 3'b101) legal = shift_upper_zero || srai_upper_ok;
      end
      OP_IMM_32: begin
        fmt   = FMT_I;
        imm   = sext32(imm_i);
        legal = RV64;
      end
      OP: begin
        fmt   = FMT_R;
        legal = op_funct7_ok;
      end
      OP_32: begin
        fmt   = FMT_R;
        legal = RV64 && op_funct7_ok;
      end
      default: legal = 1'b0;
    endcase

    if (instr[1:0] != 2'b11) legal = 1'b0;
    if (!legal) begin
      fmt = FMT_X;
      imm = '0;
    end

    fields.opcode  = opcode;
    fields.funct3  = funct3;
    fields.funct7  = funct7;
    fields.rd      = instr[11:7];
    fields.rs1     = instr[19:15];
    fields.rs2     = instr[24:20];
    fields.fmt     = fmt;
    fields.illegal = !legal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake with a two-entry skid buffer
// (OUT + SKID) so in_ready_o comes straight from a flop.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rd_addr_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_payload_t    f;
  } entry_t;

  dec_payload_t    in_fields;
  logic [XLEN-1:0] in_imm;
  entry_t          in_entry, out_q, skid_q;
  skid_state_e     state_q, state_d;
  logic            in_xfer, out_xfer;
  logic            load_out_in, load_out_skid, load_skid;

  instr_field_dec #(
    .XLEN(XLEN),
    .EN_M(EN_M)
  ) u_dec (
    .instr (instr_i),
    .fields(in_fields),
    .imm   (in_imm)
  );

  assign in_entry = '{pc: pc_i, imm: in_imm, f: in_fields};
  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  // Flush wins over handshakes; an output transfer in the flush cycle is
  // simply not undone, and the incoming instruction is never loaded.
  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d     = ONE;
            load_out_in = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_out_in = 1'b1;
          end else if (in_xfer) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d       = ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_o <= (state_d != EMPTY);
      in_ready_o  <= (state_d != TWO);
      if (load_out_in) out_q <= in_entry;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid) skid_q <= in_entry;
    end
  end

  assign opcode_o   = out_q.f.opcode;
  assign funct3_o   = out_q.f.funct3;
  assign funct7_o   = out_q.f.funct7;
  assign rd_addr_o  = out_q.f.rd;
  assign rs1_addr_o = out_q.f.rs1;
  assign rs2_addr_o = out_q.f.rs2;
  assign imm_o      = out_q.imm;
  assign pc_o       = out_q.pc;
  assign fmt_o      = out_q.f.fmt;
  assign illegal_o  = out_q.f.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three configurations (RV32, RV32+M, RV64+M) share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr_in = '0;
  logic [63:0] pc_in = '0;

  logic        a_ov, a_ir, a_ill;
  logic [6:0]  a_op, a_f7;
  logic [2:0]  a_f3, a_fmt;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [31:0] a_imm, a_pc;

  logic        b_ov, b_ir, b_ill;
  logic [6:0]  b_op, b_f7;
  logic [2:0]  b_f3, b_fmt;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [31:0] b_imm, b_pc;

  logic        c_ov, c_ir, c_ill;
  logic [6:0]  c_op, c_f7;
  logic [2:0]  c_f3, c_fmt;
  logic [4:0]  c_rd, c_rs1, c_rs2;
  logic [63:0] c_imm, c_pc;

  decode_stage #(.XLEN(32), .EN_M(1'b0)) d32 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid), .in_ready_o(a_ir),
    .instr_i(instr_in), .pc_i(pc_in[31:0]), .out_valid_o(a_ov), .out_ready_i(out_ready),
    .opcode_o(a_op), .funct3_o(a_f3), .funct7_o(a_f7), .rd_addr_o(a_rd), .rs1_addr_o(a_rs1),
    .rs2_addr_o(a_rs2), .imm_o(a_imm), .pc_o(a_pc), .fmt_o(a_fmt), .illegal_o(a_ill));

  decode_stage #(.XLEN(32), .EN_M(1'b1)) d32m (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid), .in_ready_o(b_ir),
    .instr_i(instr_in), .pc_i(pc_in[31:0]), .out_valid_o(b_ov), .out_ready_i(out_ready),
    .opcode_o(b_op), .funct3_o(b_f3), .funct7_o(b_f7), .rd_addr_o(b_rd), .rs1_addr_o(b_rs1),
    .rs2_addr_o(b_rs2), .imm_o(b_imm), .pc_o(b_pc), .fmt_o(b_fmt), .illegal_o(b_ill));

  decode_stage #(.XLEN(64), .EN_M(1'b1)) d64 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid), .in_ready_o(c_ir),
    .instr_i(instr_in), .pc_i(pc_in), .out_valid_o(c_ov), .out_ready_i(out_ready),
    .opcode_o(c_op), .funct3_o(c_f3), .funct7_o(c_f7), .rd_addr_o(c_rd), .rs1_addr_o(c_rs1),
    .rs2_addr_o(c_rs2), .imm_o(c_imm), .pc_o(c_pc), .fmt_o(c_fmt), .illegal_o(c_ill));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } txn_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;
  bit   started = 1'b0;
  bit   zero_exp = 1'b0;
  txn_t q[$];
  int   seen_rd[$];
  int   seen_cyc[$];

  // Reference decode from the ISA rules, using plain signed arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                 input bit rv64, input bit m_ext);
    exp_t   e;
    longint imm;
    bit     legal;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    e.op = ins[6:0]; e.f3 = f3; e.f7 = f7;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.pc = rv64 ? pc : {32'b0, pc[31:0]};
    legal = 1'b1;
    imm = 0;
    e.fmt = FMT_X;
    case (ins[6:0])
      7'h37, 7'h17: begin e.fmt = FMT_U; imm = $signed({ins[31:12], 12'h000}); end
      7'h6F: begin e.fmt = FMT_J; imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); end
      7'h67: begin e.fmt = FMT_I; imm = $signed(ins[31:20]); legal = (f3 == 0); end
      7'h63: begin e.fmt = FMT_B; imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                   legal = !(f3 == 2 || f3 == 3); end
      7'h03: begin e.fmt = FMT_I; imm = $signed(ins[31:20]);
                   legal = (f3 != 7) && (rv64 || (f3 != 3 && f3 != 6)); end
      7'h23: begin e.fmt = FMT_S; imm = $signed({ins[31:25], ins[11:7]});
                   legal = (f3 <= (rv64 ? 3 : 2)); end
      7'h13: begin
        e.fmt = FMT_I; imm = $signed(ins[31:20]);
        if (f3 == 1) legal = rv64 ? (ins[31:26] == 0) : (ins[31:25] == 0);
        if (f3 == 5) legal = rv64 ? (ins[31:26] == 0 || ins[31:26] == 6'h10)
                                  : (ins[31:25] == 0 || ins[31:25] == 7'h20);
      end
      7'h1B: begin e.fmt = FMT_I; imm = $signed(ins[31:20]); legal = rv64; end
      7'h33, 7'h3B: begin
        e.fmt = FMT_R;
        legal = (ins[6:0] == 7'h33 || rv64) &&
                (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && m_ext));
      end
      default: legal = 1'b0;
    endcase
    if (ins[1:0] != 2'b11) legal = 1'b0;
    if (!legal) begin e.fmt = FMT_X; imm = 0; end
    if (e.fmt == FMT_R) imm = 0;
    e.imm = rv64 ? imm : {32'b0, imm[31:0]};
    e.ill = !legal;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic checkDut(input string tag, input bit rv64, input bit m_ext,
                          input logic v, input logic r, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm,
                          input logic [63:0] pc, input logic [2:0] fmt, input logic ill);
    exp_t e;
    checkOutput({tag, ".out_valid"}, v, q.size() > 0);
    checkOutput({tag, ".in_ready"}, r, q.size() < 2);
    if (q.size() > 0 || zero_exp) begin
      e = (q.size() > 0) ? model(q[0].instr, q[0].pc, rv64, m_ext) : '0;
      checkOutput({tag, ".opcode"}, op, e.op);
      checkOutput({tag, ".funct3"}, f3, e.f3);
      checkOutput({tag, ".funct7"}, f7, e.f7);
      checkOutput({tag, ".rd"}, rd, e.rd);
      checkOutput({tag, ".rs1"}, rs1, e.rs1);
      checkOutput({tag, ".rs2"}, rs2, e.rs2);
      checkOutput({tag, ".imm"}, imm, e.imm);
      checkOutput({tag, ".pc"}, pc, e.pc);
      checkOutput({tag, ".fmt"}, fmt, e.fmt);
      checkOutput({tag, ".illegal"}, ill, e.ill);
    end
  endtask

  // Compare against the model, then predict the effect of the coming edge.
  // Inputs only change just after a rising edge, so they are stable here.
  always @(negedge clk_i) begin
    bit   in_x, out_x;
    txn_t t;
    cycle++;
    if (started) begin
      checkDut("d32", 1'b0, 1'b0, a_ov, a_ir, a_op, a_f3, a_f7, a_rd, a_rs1, a_rs2,
               {32'b0, a_imm}, {32'b0, a_pc}, a_fmt, a_ill);
      checkDut("d32m", 1'b0, 1'b1, b_ov, b_ir, b_op, b_f3, b_f7, b_rd, b_rs1, b_rs2,
               {32'b0, b_imm}, {32'b0, b_pc}, b_fmt, b_ill);
      checkDut("d64", 1'b1, 1'b1, c_ov, c_ir, c_op, c_f3, c_f7, c_rd, c_rs1, c_rs2,
               c_imm, c_pc, c_fmt, c_ill);
      if (a_ov && out_ready) begin
        seen_rd.push_back(int'(a_rd));
        seen_cyc.push_back(cycle);
      end
    end
    if (rst_i) begin
      q.delete();
      zero_exp = 1'b1;
      started  = 1'b1;
    end else if (started) begin
      in_x  = in_valid && (q.size() < 2);
      out_x = (q.size() > 0) && out_ready;
      if (flush_i) begin
        q.delete();
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) begin
          t.instr = instr_in;
          t.pc    = pc_in;
          q.push_back(t);
          zero_exp = 1'b0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Present one instruction and hold it until the stage accepts it.
  task automatic applyStimulus(input logic [31:0] ins, input logic [63:0] pc);
    bit accepted = 1'b0;
    instr_in = ins;
    pc_in    = pc;
    in_valid = 1'b1;
    for (int k = 0; k < 64 && !accepted; k++) begin
      @(negedge clk_i);
      if (a_ir) accepted = 1'b1;
    end
    checkOutput("accept_wait", accepted, 1);
    @(posedge clk_i);
    #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] vecs[17] = '{
    32'h40208133, 32'h4020C133, 32'h0000B083, 32'h00112423, 32'h00113423,
    32'hFE000EE3, 32'h000122B7, 32'h80000297, 32'h00009067, 32'h0000A063,
    32'h40105093, 32'h02005093, 32'h00000013, 32'h00000010, 32'h0000007F,
    32'h0220803B, 32'h4000D01B
  };
  logic [7:0] pat = 8'b1011_0110;

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset.out_valid", a_ov, 0);
    checkOutput("reset.in_ready", a_ir, 1);
    checkOutput("reset.imm64", c_imm, 0);
    @(posedge clk_i);
    #1 out_ready = 1'b1;

    applyStimulus(32'hFFF00093, 64'h100);
    @(negedge clk_i);
    checkOutput("addi.valid", a_ov, 1);
    checkOutput("addi.opcode", a_op, 7'b0010011);
    checkOutput("addi.rd", a_rd, 1);
    checkOutput("addi.rs1", a_rs1, 0);
    checkOutput("addi.imm32", a_imm, 32'hFFFFFFFF);
    checkOutput("addi.imm64", c_imm, 64'hFFFFFFFFFFFFFFFF);
    checkOutput("addi.fmt", a_fmt, FMT_I);
    checkOutput("addi.illegal", a_ill, 0);
    checkOutput("addi.pc", a_pc, 32'h100);
    idle(1);

    applyStimulus(32'h022081B3, 64'h104);
    @(negedge clk_i);
    checkOutput("mul.noM.illegal", a_ill, 1);
    checkOutput("mul.noM.fmt", a_fmt, FMT_X);
    checkOutput("mul.noM.rd", a_rd, 3);
    checkOutput("mul.M.illegal", b_ill, 0);
    checkOutput("mul.M.fmt", b_fmt, FMT_R);
    idle(1);

    applyStimulus(32'hFFDFF06F, 64'h108);
    @(negedge clk_i);
    checkOutput("jal.imm64", c_imm, 64'hFFFFFFFFFFFFFFFC);
    checkOutput("jal.imm32", a_imm, 32'hFFFFFFFC);
    checkOutput("jal.fmt", c_fmt, FMT_J);
    idle(1);

    applyStimulus(32'h0010009B, 64'h10C);
    @(negedge clk_i);
    checkOutput("addiw.rv64.illegal", c_ill, 0);
    checkOutput("addiw.rv64.imm", c_imm, 1);
    checkOutput("addiw.rv64.fmt", c_fmt, FMT_I);
    checkOutput("addiw.rv32.illegal", a_ill, 1);
    checkOutput("addiw.rv32.fmt", a_fmt, FMT_X);
    idle(1);

    // Back-pressure: A, B fill the buffer, C waits upstream.
    out_ready = 1'b0;
    seen_rd.delete();
    seen_cyc.delete();
    fork
      begin
        applyStimulus(32'h00000293 | (32'd5 << 7) & 32'h00000F80, 64'h200);
        applyStimulus(32'h00000313, 64'h204);
        applyStimulus(32'h00000393, 64'h208);
      end
      begin
        repeat (3) @(negedge clk_i);
        checkOutput("bp.in_ready_low", a_ir, 0);
        checkOutput("bp.out_valid", a_ov, 1);
        @(posedge clk_i);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);
    checkOutput("bp.count", seen_rd.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("bp.rd%0d", i), (seen_rd.size() > i) ? seen_rd[i] : -1, 5 + i);
    for (int i = 1; i < 3; i++)
      checkOutput($sformatf("bp.consecutive%0d", i),
                  (seen_cyc.size() > i) ? seen_cyc[i] - seen_cyc[i-1] : -1, 1);

    // Flush in TWO together with an offered instruction.
    out_ready = 1'b0;
    applyStimulus(32'h00100413, 64'h400);
    applyStimulus(32'h00200493, 64'h404);
    instr_in = 32'h00A00513; pc_in = 64'h408; in_valid = 1'b1; flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0; in_valid = 1'b0;
    @(negedge clk_i);
    checkOutput("flush2.out_valid", a_ov, 0);
    checkOutput("flush2.in_ready", a_ir, 1);
    @(posedge clk_i);
    #1 out_ready = 1'b1;
    idle(2);
    @(negedge clk_i);
    checkOutput("flush2.no_ghost", a_ov, 0);
    @(posedge clk_i);

    // Flush in ONE while the stage is ready: the offered input must be dropped.
    #1 out_ready = 1'b0;
    applyStimulus(32'h00100413, 64'h410);
    instr_in = 32'h00A00513; pc_in = 64'h414; in_valid = 1'b1; flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0; in_valid = 1'b0;
    @(negedge clk_i);
    checkOutput("flush1.out_valid", a_ov, 0);
    @(posedge clk_i);
    #1 out_ready = 1'b1;
    idle(2);

    // Reset while holding two entries.
    out_ready = 1'b0;
    applyStimulus(32'h00100413, 64'h500);
    applyStimulus(32'h00200493, 64'h504);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst2.out_valid", a_ov, 0);
    checkOutput("rst2.in_ready", a_ir, 1);
    checkOutput("rst2.imm64", c_imm, 0);
    checkOutput("rst2.pc64", c_pc, 0);
    checkOutput("rst2.opcode", c_op, 0);
    @(posedge clk_i);
    #1 out_ready = 1'b1;
    applyStimulus(32'h00100293, 64'h300);
    @(negedge clk_i);
    checkOutput("rst2.first.valid", a_ov, 1);
    checkOutput("rst2.first.pc", a_pc, 32'h300);
    checkOutput("rst2.first.rd", a_rd, 5);
    idle(1);

    // Mixed legal/illegal vectors under a fixed stall pattern.
    fork
      begin
        for (int i = 0; i < 17; i++)
          applyStimulus(vecs[i], {32'hA5A50000, 32'h1000 + 32'(4 * i)});
      end
      begin
        for (int i = 0; i < 48; i++) begin
          @(posedge clk_i);
          #1 out_ready = pat[i % 8];
        end
        out_ready = 1'b1;
      end
    join
    idle(4);
    @(negedge clk_i);
    checkOutput("drain.out_valid", a_ov, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
